// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Scans a 4x4 active-low matrix keypad one column at a time and debounces
//   whole-matrix frames. Each accepted press is reported exactly once as a
//   one-cycle start pulse, with the row/column code held on dout.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   row_n  in   [3:0] row lines, low = key closed in the driven column
//   col_n  out  [3:0] column drive, exactly one bit low
//   dout   out  [7:0] {col + INDEX_BASE, row + INDEX_BASE}, held until next press
//   start  out  one-cycle pulse, dout valid in the same cycle
//   held   out  high while an accepted key is still down
module keypad_scan_debounce #(
    parameter int CLOCK_FREQUENCY = 200000000,
    // Default settle time is 10 us of clock.
    parameter int SETTLE_CYCLES   = CLOCK_FREQUENCY / 100000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int INDEX_BASE      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] dout,
    output logic       start,
    output logic       held
);

    localparam int SLOT_W = $clog2(SETTLE_CYCLES);
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DF_C      = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]        BASE_N    = 4'(INDEX_BASE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRS_CNT = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_REL_CNT = 2'd3;

    logic [3:0]        row_s1_q, row_s1_d;
    logic [3:0]        row_s2_q, row_s2_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_q, col_d;
    logic [3:0][3:0]   frame_q, frame_d;   // [col][row], 1 = pressed
    logic              eval_q, eval_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cand_q, cand_d;     // {col, row}
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        dout_q, dout_d;
    logic              start_q, start_d;

    logic              slot_last;
    logic [4:0]        n_set;
    logic [3:0]        hit_code;
    logic              is_none, is_key;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        hit_dout;

    // Scan timing and frame capture
    always_comb begin
        row_s1_d  = row_n;
        row_s2_d  = row_s1_q;
        slot_last = (slot_q == SLOT_LAST);
        slot_d    = slot_last ? '0 : slot_q + 1'b1;
        col_d     = slot_last ? col_q + 2'd1 : col_q;
        frame_d   = frame_q;
        if (slot_last)
            frame_d[col_q] = ~row_s2_q;
        // The full frame is complete in the cycle after column 3 is sampled.
        eval_d    = slot_last && (col_q == 2'd3);
    end

    // Frame classification: hit_code is only meaningful when n_set == 1.
    always_comb begin
        n_set    = '0;
        hit_code = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (frame_q[c][r]) begin
                    n_set    = n_set + 5'd1;
                    hit_code = {2'(c), 2'(r)};
                end
            end
        end
        is_none  = (n_set == 5'd0);
        is_key   = (n_set == 5'd1);
        hit_dout = {{2'b00, hit_code[3:2]} + BASE_N, {2'b00, hit_code[1:0]} + BASE_N};
    end

    // Debounce FSM, stepped once per frame evaluation
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        start_d = 1'b0;
        cnt_inc = (cnt_q >= DF_C) ? cnt_q : cnt_q + 1'b1;
        if (eval_q) begin
            case (state_q)
                S_IDLE: begin
                    if (is_key) begin
                        cand_d = hit_code;
                        // With a single-frame debounce the first KEY frame accepts.
                        if (CNT_ONE >= DF_C) begin
                            state_d = S_HELD;
                            cnt_d   = '0;
                            dout_d  = hit_dout;
                            start_d = 1'b1;
                        end else begin
                            state_d = S_PRS_CNT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_PRS_CNT: begin
                    if (is_key && hit_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DF_C) begin
                            state_d = S_HELD;
                            cnt_d   = '0;
                            dout_d  = hit_dout;
                            start_d = 1'b1;
                        end
                    end else if (is_key) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    if (is_none) begin
                        if (CNT_ONE >= DF_C) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_REL_CNT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                default: begin // S_REL_CNT
                    if (is_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DF_C) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q <= 4'b1111;
            row_s2_q <= 4'b1111;
            slot_q   <= '0;
            col_q    <= '0;
            frame_q  <= '0;
            eval_q   <= 1'b0;
            state_q  <= S_IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            row_s1_q <= row_s1_d;
            row_s2_q <= row_s2_d;
            slot_q   <= slot_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            eval_q   <= eval_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            start_q  <= start_d;
        end
    end

    assign col_n = ~(4'b0001 << col_q);
    assign dout  = dout_q;
    assign start = start_q;
    assign held  = (state_q == S_HELD) || (state_q == S_REL_CNT);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical keypad model drives row_n from
// col_n, and a frame-level reference model predicts start/dout/held.
module tb_keypad_scan_debounce;

    localparam int SETTLE = 4;
    localparam int DF     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [7:0] dout;
    logic       start;
    logic       held;

    logic [15:0] keys = '0;   // bit c*4+r = key at column c, row r is down

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int last_start_cyc = -1;

    keypad_scan_debounce #(
        .CLOCK_FREQUENCY(200000000),
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_FRAMES(DF),
        .INDEX_BASE     (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .row_n(row_n),
        .col_n(col_n),
        .dout (dout),
        .start(start),
        .held (held)
    );

    always #5 clk = ~clk;

    // Keypad: a closed key pulls its row low when its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per frame of key masks.
    logic        m_holding = 1'b0;
    int          m_run = 0;
    int          m_none = 0;
    logic [3:0]  m_code = '0;
    logic [7:0]  m_dout = '0;
    logic [15:0] fq[$];
    logic        rst_e = 1'b0;
    int          cyc = 0;

    always @(posedge clk) rst_e <= rst;

    always @(negedge clk) begin
        logic       e_start;
        logic [15:0] m;
        int         idx;
        if (rst_e) begin
            chk("rst_col_n", {28'd0, col_n}, 32'he);
            chk("rst_start", {31'd0, start}, 32'd0);
            chk("rst_dout",  {24'd0, dout},  32'd0);
            chk("rst_held",  {31'd0, held},  32'd0);
            m_holding = 1'b0; m_run = 0; m_none = 0; m_code = '0; m_dout = '0;
            fq.delete();
            cyc = 1;
        end else begin
            e_start = 1'b0;
            if (cyc % 16 == 2) fq.push_back(keys);
            if (cyc >= 17 && cyc % 16 == 1) begin
                if (fq.size() == 0) begin
                    chk("frame_queue", 32'd0, 32'd1);
                    m = '0;
                end else begin
                    m = fq.pop_front();
                end
                idx = 0;
                for (int i = 0; i < 16; i++) if (m[i]) idx = i;
                if (!m_holding) begin
                    if ($countones(m) == 1) begin
                        m_run  = (m_run > 0 && m_code == 4'(idx)) ? m_run + 1 : 1;
                        m_code = 4'(idx);
                        if (m_run == DF) begin
                            m_holding = 1'b1;
                            m_none    = 0;
                            e_start   = 1'b1;
                            m_dout    = {4'(idx / 4 + 1), 4'(idx % 4 + 1)};
                        end
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    if (m == 16'd0) begin
                        m_none++;
                        if (m_none == DF) begin
                            m_holding = 1'b0;
                            m_run     = 0;
                        end
                    end else begin
                        m_none = 0;
                    end
                end
            end
            chk("col_n", {28'd0, col_n}, {28'd0, ~(4'b0001 << ((cyc / SETTLE) % 4))});
            chk("start", {31'd0, start}, {31'd0, e_start});
            chk("dout",  {24'd0, dout},  {24'd0, m_dout});
            chk("held",  {31'd0, held},  {31'd0, m_holding});
            if (start === 1'b1) begin
                n_start++;
                last_start_cyc = cyc;
            end
            cyc++;
        end
    end

    task automatic frames(input logic [15:0] mask, input int n);
        keys = mask;
        repeat (n * 16) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset, then scan stepping (checked every cycle)
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;

        // 2: r2c1 held from frame 0 -> start visible at cycle 49
        frames(16'h0040, 5);
        chk("t2_starts", n_start, 1);
        chk("t2_start_cyc", last_start_cyc, 49);
        chk("t2_dout", {24'd0, dout}, 32'h23);
        chk("t2_held", {31'd0, held}, 32'd1);

        // 3: release, then bounce every frame -> nothing new
        frames(16'h0000, 4);
        for (int i = 0; i < 5; i++) begin
            frames(16'h0040, 1);
            frames(16'h0000, 1);
        end
        chk("t3_starts", n_start, 1);
        chk("t3_held", {31'd0, held}, 32'd0);

        // 4: long hold, short release, full release
        frames(16'h0040, 20);
        chk("t4_starts_a", n_start, 2);
        frames(16'h0000, 2);
        frames(16'h0040, 3);
        chk("t4_starts_b", n_start, 2);
        frames(16'h0000, 3);
        frames(16'h0040, 4);
        chk("t4_starts_c", n_start, 3);

        // 5: two keys is never accepted; lifting one leaves r0c0
        frames(16'h0000, 4);
        frames(16'h8001, 6);
        chk("t5_starts_multi", n_start, 3);
        frames(16'h0001, 4);
        chk("t5_starts", n_start, 4);
        chk("t5_dout", {24'd0, dout}, 32'h11);

        // 6: reset in the middle of a press count restarts it
        frames(16'h0000, 4);
        keys = 16'h0040;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        frames(16'h0040, 4);
        chk("t6_starts", n_start, 5);
        chk("t6_start_cyc", last_start_cyc, 49);
        chk("t6_dout", {24'd0, dout}, 32'h23);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
